rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised, registered N:1 channel multiplexer with per-channel valid/ready handshake. It selects in two modes: fixed, where the select comes from an input, and round-robin arbitration. It extends the team's combinational select-tree muxes to any channel count and data width. The output is pipelined and back-pressured, and it sits between the coefficient/state producers and the shared ODE arithmetic unit.

## Interface
Parameters:
- SIZE, 16, data width in bits
- N, 16, number of input channels (2..32)
- SEL_W, $clog2(N), select/source index width (derived; not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  N*SIZE  flattened inputs; channel i at [i*SIZE +: SIZE]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready (one-hot or zero)
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel index used when mode=0
- out_data  out  SIZE  registered selected data
- out_src  out  SEL_W  index of the channel that produced out_data
- out_valid  out  1  output holds a valid word
- out_ready  in  1  downstream accepts the word

## Operation
- Output stage is one register (out_data, out_src, out_valid).
- load = !out_valid | out_ready.
- Grant selection (combinational, one-hot gnt):
  - mode=0: gnt[sel] = in_valid[sel].
  - mode=0, sel >= N: gnt = 0; no channel is ever granted.
  - mode=1: first i with in_valid[i], searching circularly from (ptr+1) mod N through ptr.
- in_ready = gnt & {N{load}}. Input transfer on channel i occurs when in_valid[i] & in_ready[i].
- On load with gnt != 0: out_data <= in_data[i], out_src <= i, out_valid <= 1.
- On load with gnt == 0: out_valid <= 0; out_data and out_src hold.
- Round-robin pointer ptr (SEL_W bits):
  - Updates to i only on an input transfer while mode=1.
  - Holds in mode=0 and on cycles without a transfer.
  - Wrap: after ptr = N-1, the search starts at 0.
- Mode or sel changes take effect on the same cycle's grant. No words are lost or duplicated, because the grant only commits on a transfer.
- Input-side contract: in_valid must not drop while waiting without a transfer. The block does not rely on this; it simply re-arbitrates.

## Timing
- Latency: transfer on cycle t -> word visible on out_data/out_valid at t+1.
- Throughput: one word per cycle while out_ready=1 and any eligible in_valid=1.
- Stall: out_valid=1 & out_ready=0 -> in_ready=0, and all outputs hold stable until accepted.
- Simultaneous out_ready=1 and new grant: the old word leaves and the new word loads in the same cycle, with no bubble.
- Reset (async assert, synchronous-release use):
  - out_valid=0, out_data=0, out_src=0, in_ready=0.
  - ptr=N-1, so index 0 has first round-robin priority.
- Reset mid-stall: the pending output word is discarded. out_valid is 0 on the first edge after deassertion.

## Structure
- Shared package/header `mux_pkg`: MODE_FIXED=1'b0, MODE_RR=1'b1, and the `$clog2`-based SEL_W helper.
- Natural sub-module: `rr_pick_n`.
  - Purely combinational circular priority pick: (req[N], ptr) -> one-hot gnt and index.
  - Instantiated once; the fixed-mode path bypasses it.
- Top module holds the output register, ptr, and the mode mux.

## Test plan
- Reset, then mode=1, N=4, SIZE=16, in_valid=4'b1111, data i=16'h00A0+i, out_ready=1.
  - out_src sequence 0,1,2,3,0.
  - out_data 00A0..00A3, one per cycle, first at cycle 1 after the first transfer.
- mode=0, sel=2, in_valid=4'b1011.
  - in_ready=0 and out_valid=0 on the next edge.
  - Then set in_valid[2]=1: in_ready=4'b0100, and out_data=in_data[2] one cycle later.
- Back-pressure: mode=1, all valid, out_ready held 0 for 3 cycles after the first word.
  - out_data/out_src stable and in_ready=0.
  - On release, the next out_src is the previous src+1 (mod N), with no repeat or skip.
- Sparse round-robin: ptr=1, in_valid=4'b1001 -> grant 3, then 0, then 3. Ptr wraps from 3 to 0.
- Mode switch: mode=1 after granting channel 2, switch to mode=0 with sel=2 for 2 words, then back to mode=1.
  - The next round-robin grant starts at 3, because ptr held in fixed mode.
- Async reset with out_valid=1 and out_ready=0.
  - Outputs go to 0 immediately, without waiting for clk.
  - After release, the first round-robin grant goes to channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and width helper for the channel multiplexer family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an n-channel select; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_n_pick.sv
// Circular priority pick: first requester after ptr, wrapping through ptr itself.
// Latency: purely combinational.
// Backpressure: none; callers qualify the grant with their own load condition.
module rr_pick_n
  import mux_pkg::*;
#(
  parameter int N     = 16,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  logic [SEL_W-1:0] j;

  // Scan (ptr+1) mod N .. ptr and latch onto the first active request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = SEL_W'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// Registered N:1 channel mux, fixed-select or round-robin, with valid/ready on both sides.
// Latency: one cycle from input transfer to out_data/out_valid.
// Backpressure: out_valid & !out_ready stalls; in_ready drops to zero and outputs hold.
module rr_mux_n
  import mux_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int N     = 16,
  parameter int SEL_W = sel_width(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*SIZE-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [SIZE-1:0]   out_data,
  output logic [SEL_W-1:0]  out_src,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SIZE-1:0]  chan [N];
  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] ptr;
  logic             load;
  logic             xfer;

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign chan[g] = in_data[g*SIZE +: SIZE];
  end

  rr_pick_n #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Output register can take a word when empty or when its word is leaving now.
  assign load = !out_valid || out_ready;
  assign xfer = load && (|gnt);

  // In reset the grant is masked so no producer sees a transfer it cannot complete.
  assign in_ready = gnt & {N{load & rst_n}};

  // Mode mux: fixed select bypasses the arbiter; an out-of-range sel never grants.
  always_comb begin
    gnt     = '0;
    gnt_idx = sel;
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
    end else if (int'(sel) < N) begin
      gnt[sel] = in_valid[sel];
    end
  end

  // Output stage: load the granted word, or go empty and keep the last data/src.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= |gnt;
      if (|gnt) begin
        out_data <= chan[gnt_idx];
        out_src  <= gnt_idx;
      end
    end
  end

  // Round-robin pointer advances only on a round-robin transfer; reset gives index 0 first pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SEL_W'(N - 1);
    end else if (xfer && (mode == MODE_RR)) begin
      ptr <= rr_idx;
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
module tb_rr_mux_n;

  localparam int N     = 4;
  localparam int SIZE  = 16;
  localparam int SEL_W = 2;
  localparam int NV    = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*SIZE-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [SIZE-1:0]   out_data;
  logic [SEL_W-1:0]  out_src;
  logic              out_valid;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     valid;
    logic             ordy;
    logic [N-1:0]     exp_rdy;
    logic             exp_vld;
    logic [SEL_W-1:0] exp_src;
    logic [SIZE-1:0]  exp_dat;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  rr_mux_n #(.SIZE(SIZE), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) in_data[i*SIZE +: SIZE] = SIZE'(16'h00A0 + i);

    // mode sel valid ordy | in_ready (before edge) | out_valid out_src out_data (after edge)
    // round-robin, all valid: 0,1,2,3,0
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00A0};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h00A1};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00A0};
    // fixed sel=2 with channel 2 idle, then active
    vecs[5]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h00A0};
    vecs[6]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    // back-pressure: ptr held at 0 through fixed mode, so next is 1; stall 3 cycles
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h00A1};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h00A1};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h00A1};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h00A1};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    // sparse 1001: 3, 0 (wrap), 3
    vecs[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    vecs[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00A0};
    vecs[14] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    // mode switch: rr grants 2, fixed sel=2 twice, rr resumes at 3
    vecs[15] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    vecs[16] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    vecs[17] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h00A2};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h00A3};
    // nothing valid: output empties, data/src hold
    vecs[19] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h00A3};

    // Reset with requests pending: nothing may be offered ready.
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    check("reset_vld", 32'(out_valid), 32'd0);
    check("reset_src", 32'(out_src),   32'd0);
    check("reset_dat", 32'(out_data),  32'd0);
    check("reset_rdy", 32'(in_ready),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_vld", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      check($sformatf("v%0d_src", i), 32'(out_src),   32'(vecs[i].exp_src));
      check($sformatf("v%0d_dat", i), 32'(out_data),  32'(vecs[i].exp_dat));
    end

    // Async reset during a stall: ptr was 3, grant 0 moves it to 0; reset must restore 3.
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("ar_pre_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("ar_pre_vld", 32'(out_valid), 32'd1);
    check("ar_pre_dat", 32'(out_data),  32'h00A0);
    out_ready = 1'b0;
    #1;
    check("ar_stall_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("ar_vld", 32'(out_valid), 32'd0);
    check("ar_src", 32'(out_src),   32'd0);
    check("ar_dat", 32'(out_data),  32'd0);
    check("ar_rdy", 32'(in_ready),  32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("ar_post_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("ar_post_vld", 32'(out_valid), 32'd1);
    check("ar_post_src", 32'(out_src),   32'd0);
    check("ar_post_dat", 32'(out_data),  32'h00A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
